lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have ports `clk` (in, 1, sole clock, rising edge) and `rst_n` (in, 1, asynchronous active-low reset), listed first.
REQ-004 SHALL have pipeline-side inputs:
- `MemRead` (1): load request.
- `MemWrite` (1): store request.
- `Funct3` (3): access size/sign.
- `a` (DM_ADDRESS): byte address.
- `wd` (DATA_W): store data.
REQ-005 SHALL have pipeline-side outputs:
- `rd` (DATA_W): formatted load data.
- `lsu_busy` (1): pipeline stall.
- `lsu_done` (1): one-cycle completion pulse.
- `misalign` (1): misaligned-access pulse.
REQ-006 SHALL have memory-side outputs:
- `mem_req` (1).
- `mem_we` (1).
- `mem_be` (4): byte enables.
- `mem_addr` (DM_ADDRESS): word-aligned, bits [1:0] = 0.
- `mem_wdata` (DATA_W).
REQ-007 SHALL have memory-side inputs `mem_gnt` (1, request accepted), `mem_rvalid` (1, read data valid) and `mem_rdata` (DATA_W).

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT_R and DONE.
REQ-009 SHALL, in IDLE with MemRead or MemWrite high and a legal access, register the access attributes and move to REQ next cycle; MemRead SHALL win if both are high.
REQ-010 SHALL hold `mem_req`=1 with stable `mem_we`/`mem_be`/`mem_addr`/`mem_wdata` for as long as the FSM is in REQ and `mem_gnt`=0.
REQ-011 SHALL, on `mem_gnt`=1 in REQ, go to DONE for a store or to WAIT_R for a load.
REQ-012 SHALL ignore `mem_rvalid` outside WAIT_R; on `mem_rvalid`=1 in WAIT_R it SHALL register the formatted `mem_rdata` into `rd` and go to DONE.
REQ-013 SHALL assert `lsu_done` only in DONE, for exactly one cycle, then return to IDLE.
REQ-014 SHALL drive `lsu_busy`=1 whenever state is not IDLE; `rd` SHALL hold its value until the next load completes.
REQ-015 SHALL give a minimum latency, from the request cycle in IDLE to `lsu_done`, of 2 cycles for a store (gnt in the first REQ cycle) and 3 cycles for a load (rvalid in the cycle after gnt).
REQ-016 SHALL decode load Funct3 as LB 000, LH 001, LW 010, LBU 100, LHU 101 and store Funct3 as SB 000, SH 001, SW 010; any other code SHALL be treated as a word access.
REQ-017 SHALL generate byte enables as:
- Byte: `mem_be` = 4'b0001 shifted left by a[1:0].
- Half: 4'b0011 shifted left by {a[1],0}.
- Word: 4'b1111.
REQ-018 SHALL replicate store data across lanes: byte wd[7:0] four times, half wd[15:0] twice, word wd unchanged.
REQ-019 SHALL, for loads, extract the addressed byte or half lane from `mem_rdata`, then sign-extend it (LB/LH) or zero-extend it (LBU/LHU).
REQ-020 SHALL ignore MemRead/MemWrite while busy; requests are sampled only in IDLE.

Reset
REQ-021 SHALL, while `rst_n`=0:
- force state to IDLE;
- force `rd`=0 and `lsu_done`, `misalign`, `mem_req`, `mem_we` to 0;
- force `mem_be`=0, `mem_addr`=0 and `mem_wdata`=0.
REQ-022 SHALL, on reset mid-transaction, drop `mem_req` immediately and abandon the access; a late `mem_rvalid` after reset SHALL be ignored.

Configuration
REQ-023 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, treat as misaligned a half access with a[0]=1 or a word access with a[1:0]≠0.
REQ-024 SHALL, for a misaligned access, issue no `mem_req`, go directly from IDLE to DONE, pulse `misalign` and `lsu_done` together, and leave `rd` unchanged.
REQ-025 SHALL, with LSU_MISALIGN_TRAP_EN undefined, tie `misalign` to 0, force a[0] to 0 for half accesses and a[1:0] to 0 for word accesses, and proceed normally.

Structure
REQ-026 SHALL place the FSM state enum and the Funct3 load/store localparams in shared package lsu_pkg.
REQ-027 SHALL place byte-enable generation, store replication and load extract/extend in a combinational sub-module lsu_align, instantiated once.

Verification
REQ-028 SHALL cover SW: a=0x010, wd=0xDEADBEEF, gnt in the first REQ cycle -> mem_be=1111, mem_addr=0x010, mem_wdata=0xDEADBEEF, lsu_done 2 cycles after the request.
REQ-029 SHALL cover SB: a=0x013, wd=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x010.
REQ-030 SHALL cover LB and LBU: a=0x012, mem_rdata=0x00800000 -> LB rd=0xFFFFFF80 and LBU rd=0x00000080, each 3 cycles after the request.
REQ-031 SHALL cover gnt withheld for 4 cycles on an LH at a=0x002 -> mem_req and all mem_* outputs stable throughout, and mem_rdata=0x8001xxxx gives rd=0xFFFF8001.
REQ-032 SHALL cover LW at a=0x005 -> with the macro: misalign=1 and lsu_done=1 in the same cycle, no mem_req; without it: mem_addr=0x004.
REQ-033 SHALL cover `rst_n` low during WAIT_R, followed by a mem_rvalid pulse -> mem_req=0, state IDLE, rd=0, no lsu_done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, Funct3 codes,
// access-size type and the Funct3 size decoder.
package lsu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Unknown codes fall back to a word access.
  function automatic lsu_size_e decode_size(input logic [2:0] f3, input logic is_load);
    lsu_size_e sz;
    sz = SZ_WORD;
    if (is_load) begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store-data replication and
// load-data extraction with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  lsu_size_e         size,
  input  logic [1:0]        lane,
  input  logic              uns,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_fmt
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{lane, 3'b000} +: 8];
    half_sel  = rdata[{lane[1], 4'b0000} +: 16];
    be        = 4'b1111;
    wdata     = wd;
    rdata_fmt = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata     = {4{wd[7:0]}};
        rdata_fmt = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {lane[1], 1'b0};
        wdata     = {2{wd[15:0]}};
        rdata_fmt = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata     = wd;
        rdata_fmt = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller bridging the pipeline to a req/gnt/rvalid data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
//
// state   | meaning
// IDLE    | waiting for MemRead/MemWrite
// REQ     | mem_req high, waiting for mem_gnt
// WAIT_R  | load granted, waiting for mem_rvalid
// DONE    | lsu_done pulse (and misalign pulse when trapped)
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic                  misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic [1:0]            state;
  lsu_size_e             req_size, size_q, size_sel;
  logic                  req_uns, uns_q;
  logic [1:0]            lane_q, lane_sel;
  logic [DM_ADDRESS-1:0] a_eff;
  logic                  mis_req, mis_q;
  logic [3:0]            be_c;
  logic [DATA_W-1:0]     wdata_c, rd_c;

  always_comb begin
    req_size = decode_size(Funct3, MemRead);
    req_uns  = MemRead & Funct3[2];
    a_eff    = a;
    mis_req  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_req  = ((req_size == SZ_HALF) && a[0]) || ((req_size == SZ_WORD) && (a[1:0] != 2'b00));
`else
    // Without trapping, misaligned low bits are simply dropped.
    if (req_size == SZ_HALF) a_eff[0] = 1'b0;
    if (req_size == SZ_WORD) a_eff[1:0] = 2'b00;
`endif
  end

  // The single align instance serves the store path in IDLE and the load path afterwards.
  assign size_sel = (state == ST_IDLE) ? req_size   : size_q;
  assign lane_sel = (state == ST_IDLE) ? a_eff[1:0] : lane_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size      (size_sel),
    .lane      (lane_sel),
    .uns       (uns_q),
    .wd        (wd),
    .rdata     (mem_rdata),
    .be        (be_c),
    .wdata     (wdata_c),
    .rdata_fmt (rd_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd        <= '0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      size_q    <= SZ_WORD;
      uns_q     <= 1'b0;
      lane_q    <= 2'b00;
      mis_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MemRead || MemWrite) begin
            size_q <= req_size;
            uns_q  <= req_uns;
            lane_q <= a_eff[1:0];
            mis_q  <= mis_req;
            if (mis_req) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_REQ;
              mem_we    <= ~MemRead;
              mem_be    <= be_c;
              mem_addr  <= {a_eff[DM_ADDRESS-1:2], 2'b00};
              mem_wdata <= wdata_c;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) state <= mem_we ? ST_DONE : ST_WAIT_R;
        end
        ST_WAIT_R: begin
          if (mem_rvalid) begin
            rd    <= rd_c;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          mis_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req  = (state == ST_REQ);
  assign lsu_busy = (state != ST_IDLE);
  assign lsu_done = (state == ST_DONE);
  assign misalign = (state == ST_DONE) && mis_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; honours LSU_MISALIGN_TRAP_EN if defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        lsu_busy, lsu_done, misalign;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .a          (a),
    .wd         (wd),
    .rd         (rd),
    .lsu_busy   (lsu_busy),
    .lsu_done   (lsu_done),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 0; MemWrite = 0; Funct3 = 3'b000; a = '0; wd = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
    chk("rst_done", {31'd0, lsu_done}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SW a=0x010
    MemWrite = 1; Funct3 = 3'b010; a = 9'h010; wd = 32'hDEADBEEF;
    tick();
    MemWrite = 0;
    chk("sw_req", {31'd0, mem_req}, 32'd1);
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_be", {28'd0, mem_be}, 32'hF);
    chk("sw_addr", {23'd0, mem_addr}, 32'h010);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_done_early", {31'd0, lsu_done}, 32'd0);
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    chk("sw_done", {31'd0, lsu_done}, 32'd1);
    chk("sw_req_off", {31'd0, mem_req}, 32'd0);
    tick();
    chk("sw_done_1cyc", {31'd0, lsu_done}, 32'd0);
    chk("sw_idle", {31'd0, lsu_busy}, 32'd0);

    // SB a=0x013
    MemWrite = 1; Funct3 = 3'b000; a = 9'h013; wd = 32'h000000A5;
    tick();
    MemWrite = 0;
    chk("sb_be", {28'd0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_addr", {23'd0, mem_addr}, 32'h010);
    mem_gnt = 1; tick(); mem_gnt = 0;
    chk("sb_done", {31'd0, lsu_done}, 32'd1);
    tick();

    // SH a=0x006
    MemWrite = 1; Funct3 = 3'b001; a = 9'h006; wd = 32'h1234BEEF;
    tick();
    MemWrite = 0;
    chk("sh_be", {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("sh_addr", {23'd0, mem_addr}, 32'h004);
    mem_gnt = 1; tick(); mem_gnt = 0;
    tick();

    // LB a=0x012
    MemRead = 1; Funct3 = 3'b000; a = 9'h012; wd = '0;
    tick();
    MemRead = 0;
    chk("lb_we", {31'd0, mem_we}, 32'd0);
    chk("lb_be", {28'd0, mem_be}, 32'h4);
    chk("lb_addr", {23'd0, mem_addr}, 32'h010);
    mem_gnt = 1; tick(); mem_gnt = 0;
    chk("lb_wait_req", {31'd0, mem_req}, 32'd0);
    chk("lb_wait_done", {31'd0, lsu_done}, 32'd0);
    mem_rvalid = 1; mem_rdata = 32'h00800000;
    tick();
    mem_rvalid = 0;
    chk("lb_done", {31'd0, lsu_done}, 32'd1);
    chk("lb_rd", rd, 32'hFFFFFF80);
    tick();

    // LBU a=0x012
    MemRead = 1; Funct3 = 3'b100; a = 9'h012;
    tick();
    MemRead = 0;
    mem_gnt = 1; tick(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h00800000;
    tick();
    mem_rvalid = 0;
    chk("lbu_done", {31'd0, lsu_done}, 32'd1);
    chk("lbu_rd", rd, 32'h00000080);
    tick();

    // LH a=0x002 with gnt withheld 4 cycles; stray rvalid during REQ is ignored
    MemRead = 1; Funct3 = 3'b001; a = 9'h002;
    tick();
    MemRead = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEAD0000;
    for (int i = 0; i < 4; i++) begin
      chk("lh_hold_req", {31'd0, mem_req}, 32'd1);
      chk("lh_hold_be", {28'd0, mem_be}, 32'hC);
      chk("lh_hold_addr", {23'd0, mem_addr}, 32'h000);
      chk("lh_hold_wdata", mem_wdata, 32'h0);
      chk("lh_hold_we", {31'd0, mem_we}, 32'd0);
      tick();
    end
    mem_rvalid = 0;
    chk("lh_req_still", {31'd0, mem_req}, 32'd1);
    chk("lh_rd_unchanged", rd, 32'h00000080);
    mem_gnt = 1; tick(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h80011234;
    tick();
    mem_rvalid = 0;
    chk("lh_done", {31'd0, lsu_done}, 32'd1);
    chk("lh_rd", rd, 32'hFFFF8001);
    tick();

    // LHU a=0x000 with MemRead and MemWrite both high: read wins
    MemRead = 1; MemWrite = 1; Funct3 = 3'b101; a = 9'h000; wd = 32'hFFFFFFFF;
    tick();
    MemRead = 0; MemWrite = 0;
    chk("lhu_we", {31'd0, mem_we}, 32'd0);
    chk("lhu_be", {28'd0, mem_be}, 32'h3);
    mem_gnt = 1; tick(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h1234F00D;
    tick();
    mem_rvalid = 0;
    chk("lhu_rd", rd, 32'h0000F00D);
    tick();

    // LW a=0x005
    MemRead = 1; Funct3 = 3'b010; a = 9'h005; wd = '0;
    tick();
    MemRead = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_flag", {31'd0, misalign}, 32'd1);
    chk("lw_mis_done", {31'd0, lsu_done}, 32'd1);
    chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
    chk("lw_mis_rd", rd, 32'h0000F00D);
    tick();
    chk("lw_mis_clear", {31'd0, misalign}, 32'd0);
    chk("lw_mis_idle", {31'd0, lsu_busy}, 32'd0);
`else
    chk("lw_addr", {23'd0, mem_addr}, 32'h004);
    chk("lw_req", {31'd0, mem_req}, 32'd1);
    chk("lw_misalign", {31'd0, misalign}, 32'd0);
    mem_gnt = 1; tick(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h11223344;
    tick();
    mem_rvalid = 0;
    chk("lw_rd", rd, 32'h11223344);
    chk("lw_misalign_done", {31'd0, misalign}, 32'd0);
    tick();
`endif

    // Reset while in REQ drops mem_req at once
    MemRead = 1; Funct3 = 3'b010; a = 9'h010;
    tick();
    MemRead = 0;
    chk("rq_req_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rq_req_reset", {31'd0, mem_req}, 32'd0);
    chk("rq_be_reset", {28'd0, mem_be}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // LW into WAIT_R, then reset, then a late rvalid
    MemRead = 1; Funct3 = 3'b010; a = 9'h020;
    tick();
    MemRead = 0;
    mem_gnt = 1; tick(); mem_gnt = 0;
    chk("wr_busy_before", {31'd0, lsu_busy}, 32'd1);
    rst_n = 1'b0; #1;
    chk("wr_req", {31'd0, mem_req}, 32'd0);
    chk("wr_busy", {31'd0, lsu_busy}, 32'd0);
    chk("wr_rd", rd, 32'd0);
    chk("wr_addr", {23'd0, mem_addr}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1; mem_rdata = 32'hCAFEBABE;
    tick();
    mem_rvalid = 0;
    chk("wr_late_done", {31'd0, lsu_done}, 32'd0);
    chk("wr_late_rd", rd, 32'd0);
    tick();
    chk("wr_late_done2", {31'd0, lsu_done}, 32'd0);
    chk("wr_late_busy", {31'd0, lsu_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
